// File: rtl/ram_read_arbiter.sv
// Round-robin read arbiter sharing one registered-output RAM read port
// among C_REQ_NUM requesters, with a single outstanding response slot.
module ram_read_arbiter #(
    parameter int unsigned C_DATA_WIDTH    = 8,
    parameter int unsigned C_ADDRESS_WIDTH = 8,
    parameter int unsigned C_REQ_NUM       = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 arb_en,
    input  logic [C_REQ_NUM-1:0]                 req_valid,
    input  logic [C_REQ_NUM*C_ADDRESS_WIDTH-1:0] req_addr,
    output logic [C_REQ_NUM-1:0]                 req_ready,
    output logic [C_REQ_NUM-1:0]                 rsp_valid,
    input  logic [C_REQ_NUM-1:0]                 rsp_ready,
    output logic [C_DATA_WIDTH-1:0]              rsp_data,
    output logic                                 ram_re,
    output logic [C_ADDRESS_WIDTH-1:0]           ram_addr,
    input  logic [C_DATA_WIDTH-1:0]              ram_q
);

    localparam int unsigned ID_W    = (C_REQ_NUM > 1) ? $clog2(C_REQ_NUM) : 1;
    localparam int unsigned LAST_ID = C_REQ_NUM - 1;

    logic            pend_q, pend_d;
    logic [ID_W-1:0] pend_id_q, pend_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic            drain;
    logic            can_issue;
    logic            grant;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < C_REQ_NUM; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= C_REQ_NUM) begin
                idx = idx - C_REQ_NUM;
            end
            if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[ID_W-1:0];
            end
        end
    end

    // Issue gating: the single response slot must be free or draining this cycle.
    always_comb begin
        drain     = pend_q & rsp_ready[pend_id_q];
        can_issue = arb_en & (~pend_q | drain) & ~reset;
        grant     = can_issue & gnt_found;
    end

    // Request-side handshake and RAM port drive.
    always_comb begin
        req_ready = '0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        if (grant) begin
            req_ready = C_REQ_NUM'(1) << gnt_id;
            ram_re    = 1'b1;
            ram_addr  = req_addr[gnt_id*C_ADDRESS_WIDTH +: C_ADDRESS_WIDTH];
        end
    end

    // Response side: the RAM holds its output until the next read, so no data register.
    always_comb begin
        rsp_valid = '0;
        if (pend_q) begin
            rsp_valid = C_REQ_NUM'(1) << pend_id_q;
        end
        rsp_data = ram_q;
    end

    // Next-state for the pending slot and round-robin pointer.
    always_comb begin
        pend_d    = pend_q;
        pend_id_d = pend_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant) begin
            pend_d    = 1'b1;
            pend_id_d = gnt_id;
            rr_ptr_d  = (gnt_id == ID_W'(LAST_ID)) ? '0 : gnt_id + ID_W'(1);
        end else if (drain) begin
            pend_d = 1'b0;
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule
